// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Command-driven sequencer for the A/B operand registers, the ALU and the
// output register. One {a, b, sel} command is accepted over a valid/ready
// handshake. The datapath is then stepped: load A, load B, let the ALU
// settle, capture the result and strobe the output register. The captured
// {result, overflow} is returned over a second valid/ready handshake.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds valid and its data
// until that edge. The sequencer never waits on its own ready/valid to
// decide whether to raise the other one.
//
// Optional build macro: SEQ_OVF_TRAP_EN
//   defined   - returning a result with overflow set parks the sequencer
//               in TRAP until trap_clr is pulsed.
//   undefined - no trap; overflow is reported on res_ovf only, trap = 0.
//
// Parameters
//   WIDTH   operand/result width
//   SEL_W   ALU op-select width
//   SETTLE  cycles spent in EXEC before capture (>= 1)
//   CNT_W   width of the completed-operation counter
//
// Ports
//   clk, rst_n            datapath clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_a, cmd_b, cmd_sel payload
//   ld_data               data bus to the operand registers (0 when idle)
//   ld_a_en, ld_b_en      operand register enables (1-cycle pulses)
//   alu_sel               op select, held from the accepted command
//   alu_rout, alu_ovf     ALU result and overflow
//   out_en                output register enable strobe (1-cycle pulse)
//   res_valid/res_ready   result handshake; res_data, res_ovf payload
//   busy                  high in every state except IDLE
//   op_count              completed operations, wraps
//   trap, trap_clr        overflow trap status / clear
//   dbg_state             current FSM state, for checkers and debug
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SEL_W  = 3,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic [WIDTH-1:0] ld_data,
    output logic             ld_a_en,
    output logic             ld_b_en,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_rout,
    input  logic             alu_ovf,
    output logic             out_en,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             trap,
    input  logic             trap_clr,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD_A = 3'd1,
        S_LD_B = 3'd2,
        S_EXEC = 3'd3,
        S_CAPT = 3'd4,
        S_RESP = 3'd5,
        S_TRAP = 3'd6
    } state_t;

    // The settle counter only needs to hold SETTLE-1.
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);

    state_t           state;
    state_t           state_nx;
    logic             armed;     // low during reset so cmd_ready stays 0 there
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [SEL_W-1:0] sel_q;
    logic [SCW-1:0]   settle_cnt;
    logic             accept;

    assign accept = cmd_valid && cmd_ready;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            settle_cnt <= '0;
            res_data   <= '0;
            res_ovf    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;

            if (accept) begin
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                sel_q <= cmd_sel;
            end

            // Loaded on the way into EXEC; EXEC leaves once it reads 0.
            if (state == S_LD_B) begin
                settle_cnt <= SETTLE_LAST;
            end else if (state == S_EXEC && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SCW'(1);
            end

            if (state == S_CAPT) begin
                res_data <= alu_rout;
                res_ovf  <= alu_ovf;
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        ld_data   = '0;
        ld_a_en   = 1'b0;
        ld_b_en   = 1'b0;
        out_en    = 1'b0;
        res_valid = 1'b0;
        trap      = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = armed;
                if (cmd_valid && armed) begin
                    state_nx = S_LD_A;
                end
            end
            S_LD_A: begin
                ld_data  = a_q;
                ld_a_en  = 1'b1;
                state_nx = S_LD_B;
            end
            S_LD_B: begin
                ld_data  = b_q;
                ld_b_en  = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (settle_cnt == '0) begin
                    state_nx = S_CAPT;
                end
            end
            S_CAPT: begin
                out_en   = 1'b1;
                state_nx = S_RESP;
            end
            S_RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
`ifdef SEQ_OVF_TRAP_EN
                    state_nx = res_ovf ? S_TRAP : S_IDLE;
`else
                    state_nx = S_IDLE;
`endif
                end
            end
            S_TRAP: begin
`ifdef SEQ_OVF_TRAP_EN
                trap = 1'b1;
                if (trap_clr) begin
                    state_nx = S_IDLE;
                end
`else
                // Unreachable in this build; recover rather than stick.
                state_nx = S_IDLE;
`endif
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

`ifndef SEQ_OVF_TRAP_EN
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
`endif

    assign busy      = (state != S_IDLE);
    assign alu_sel   = sel_q;
    assign dbg_state = state;

endmodule
